vga_timing_core: RTL

//  Parametrised VGA raster timing generator; next generation of the snake display timing front end.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_pce_gen.sv | 24 ++
 rtl/vga_timing_core.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, coordinate width, sync bundle type and a clog2 helper
package vga_pkg;
  localparam int H_DISPLAY_D = 1366;
  localparam int H_FP_D = 70;
  localparam int H_SYNC_D = 143;
  localparam int H_BP_D = 213;
  localparam int V_DISPLAY_D = 768;
  localparam int V_FP_D = 3;
  localparam int V_SYNC_D = 3;
  localparam int V_BP_D = 24;
  localparam int COORD_WIDTH = 11;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/vga_pce_gen.sv
// vga_pce_gen: fractional pixel-clock enable, NUM pulses every DEN clocks
//   clk, reset : system clock, synchronous active-high reset
//   pix_ce     : registered enable, pattern set by the accumulator
module vga_pce_gen import vga_pkg::*; #(
  parameter int NUM = 6,
  parameter int DEN = 7
) (
  input  logic clk,
  input  logic reset,
  output logic pix_ce
);
  localparam int AW = clog2(DEN) + 1;
  logic [AW-1:0] acc, sum;
  assign sum = acc + AW'(NUM);
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      pix_ce <= 1'b0;
    end else begin
      acc <= (sum >= AW'(DEN)) ? sum - AW'(DEN) : sum;
      pix_ce <= (sum >= AW'(DEN));
    end
  end
endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: VGA raster timing with fractional pixel enable, delayed sync/DE and vblank update handshake
//   clk, reset            : 100 MHz clock, synchronous active-high reset
//   pix_ce                : pixel enable, raster state advances only when high
//   pix_x, pix_y, active  : undelayed raster position and visible-area flag
//   line_start/frame_start: 1-clk pulses aligned with pix_x (and pix_y) becoming 0
//   hsync, vsync, de      : PIPE_DELAY pixel-enables late, sync polarity per HS_POL/VS_POL
//   frame_count           : frames completed, wraps
//   upd_req / upd_ack     : level request, 1-clk ack at vblank entry
module vga_timing_core import vga_pkg::*; #(
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PCE_NUM = 6,
  parameter int PCE_DEN = 7,
  parameter int PIPE_DELAY = 2,
  parameter int X_W = COORD_WIDTH,
  parameter int Y_W = COORD_WIDTH - 1
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_ce,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [15:0]    frame_count,
  input  logic           upd_req,
  output logic           upd_ack
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  logic [X_W-1:0] h, h_nx;
  logic [Y_W-1:0] v, v_nx;
  logic h_wrap;
  sync_t raw;
  sync_t dl [0:PIPE_DELAY];
  vga_pce_gen #(.NUM(PCE_NUM), .DEN(PCE_DEN)) u_pce (.clk(clk), .reset(reset), .pix_ce(pix_ce));
  always_comb begin
    h_wrap = (h == X_W'(H_TOTAL - 1));
    h_nx = h_wrap ? '0 : h + 1'b1;
    v_nx = !h_wrap ? v : (v == Y_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    raw.hs = (h_nx >= X_W'(H_DISPLAY + H_FP)) && (h_nx < X_W'(H_DISPLAY + H_FP + H_SYNC));
    raw.vs = (v_nx >= Y_W'(V_DISPLAY + V_FP)) && (v_nx < Y_W'(V_DISPLAY + V_FP + V_SYNC));
    raw.de = (h_nx < X_W'(H_DISPLAY)) && (v_nx < Y_W'(V_DISPLAY));
  end
  // dl[0] is registered alongside h/v so it carries the undelayed flags; dl[k] is k pixel-enables late
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      upd_ack <= 1'b0;
      for (int i = 0; i <= PIPE_DELAY; i++) dl[i] <= '0;
    end else begin
      line_start <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && (v_nx == '0);
      upd_ack <= pix_ce && h_wrap && (v_nx == Y_W'(V_DISPLAY)) && upd_req;
      if (pix_ce) begin
        h <= h_nx;
        v <= v_nx;
        dl[0] <= raw;
        for (int i = 1; i <= PIPE_DELAY; i++) dl[i] <= dl[i-1];
        if (h_wrap && (v_nx == '0)) frame_count <= frame_count + 16'd1;
      end
    end
  end
  assign pix_x = h;
  assign pix_y = v;
  assign active = dl[0].de;
  assign hsync = dl[PIPE_DELAY].hs ^ ~HS_POL;
  assign vsync = dl[PIPE_DELAY].vs ^ ~VS_POL;
  assign de = dl[PIPE_DELAY].de;
endmodule
